// File: rtl/counter_sum_pkg.sv
// Shared sizing helpers for the counter sum tree: tree depth and per-level node width.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package counter_sum_pkg;

    function automatic int clog2(input int value);
        int levels;
        int span;
        levels = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Number of registered adder levels needed to reduce `channels` leaves to one node.
    function automatic int tree_levels(input int channels);
        return clog2(channels);
    endfunction

    // Every level adds one carry bit, so no node ever truncates.
    function automatic int node_width(input int width, input int level);
        return width + level;
    endfunction

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_LEVELS   = tree_levels(DEF_CHANNELS);

endpackage

// File: rtl/counter_sum_tree_if.sv
// Control and result bundle between a stimulus source and the counter sum tree.
// Latency: combinational wiring only.
// Backpressure: none; results are qualified by valid and never stall.
interface counter_sum_tree_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] en;
    logic                clear;
    logic [WIDTH-1:0]    sum;
    logic                overflow;
    logic                overflow_seen;
    logic                valid;

    modport master (
        output en,
        output clear,
        input  sum,
        input  overflow,
        input  overflow_seen,
        input  valid
    );

    modport slave (
        input  en,
        input  clear,
        output sum,
        output overflow,
        output overflow_seen,
        output valid
    );
endinterface

// File: rtl/add_stage.sv
// One registered adder-tree level: pairs of IN_WIDTH inputs summed into IN_WIDTH+1 outputs.
// Latency: 1 cycle.
// Backpressure: none; a new level result is captured every cycle.
module add_stage
    import counter_sum_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int NODES    = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [2*NODES*IN_WIDTH-1:0]                    din,
    output logic [NODES*node_width(IN_WIDTH, 1)-1:0]       dout
);
    localparam int OW = node_width(IN_WIDTH, 1);

    logic [NODES*OW-1:0] sum_nxt;

    for (genvar n = 0; n < NODES; n++) begin : g_node
        assign sum_nxt[n*OW +: OW] = {1'b0, din[(2*n)*IN_WIDTH +: IN_WIDTH]}
                                   + {1'b0, din[(2*n+1)*IN_WIDTH +: IN_WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
        end else begin
            dout <= sum_nxt;
        end
    end

endmodule

// File: rtl/counter_sum_tree.sv
// CHANNELS enable-gated wrap counters summed by a registered binary tree, with overflow tracking.
// Latency: counter samples reach sum/overflow LEVELS cycles later; valid after LEVELS edges out of reset.
// Backpressure: none; outputs update every cycle and are qualified by valid only.
module counter_sum_tree
    import counter_sum_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STEP     = 1
) (
    input  logic           clk,
    input  logic           rst,
    counter_sum_tree_if.slave bus
);
    localparam int LEVELS = tree_levels(CHANNELS);
    localparam int FW     = node_width(WIDTH, LEVELS);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    if (WIDTH < 2 || CHANNELS < 2 || CHANNELS > 16 || (1 << LEVELS) != CHANNELS) begin : g_param_chk
        $error("counter_sum_tree: WIDTH must be >= 2 and CHANNELS a power of two in 2..16");
    end

    logic [WIDTH-1:0]  cnt [CHANNELS];
    logic [LEVELS-1:0] vld_sr;
    logic              seen_q;
    logic [FW-1:0]     final_node;
    logic              valid_int;
    logic              ovf_int;

    // Counters wrap naturally through WIDTH-bit addition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.en[i]) cnt[i] <= cnt[i] + STEP_W;
            end
        end
    end

    // Level 0 is the flattened counter vector; level k is produced by add_stage from level k-1.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int NW = node_width(WIDTH, k);
        localparam int NN = CHANNELS >> k;

        logic [NN*NW-1:0] node_dat;

        if (k == 0) begin : g_leaf
            for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt
                assign node_dat[i*WIDTH +: WIDTH] = cnt[i];
            end
        end else begin : g_node
            add_stage #(
                .IN_WIDTH (NW - 1),
                .NODES    (NN)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .din  (g_lvl[k-1].node_dat),
                .dout (node_dat)
            );
        end
    end

    assign final_node = g_lvl[LEVELS].node_dat;
    assign ovf_int    = |final_node[FW-1:WIDTH];

    // Valid tracks tree fill only; clear leaves it alone since samples keep flowing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= LEVELS'({vld_sr, 1'b1});
        end
    end

    assign valid_int = vld_sr[LEVELS-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            seen_q <= 1'b0;
        end else if (bus.clear) begin
            seen_q <= 1'b0;
        end else if (valid_int && ovf_int) begin
            seen_q <= 1'b1;
        end
    end

    assign bus.sum           = final_node[WIDTH-1:0];
    assign bus.overflow      = ovf_int;
    assign bus.valid         = valid_int;
    assign bus.overflow_seen = seen_q;

endmodule

// File: tb/tb_counter_sum_tree.sv
// Scoreboard bench for counter_sum_tree (WIDTH=8, CHANNELS=4, STEP=1).
// Driver pushes expectations per edge; a negedge monitor pops and compares.
module tb_counter_sum_tree;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    counter_sum_tree_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    counter_sum_tree #(
        .WIDTH    (8),
        .CHANNELS (4),
        .STEP     (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         edge_n;
        string      name;
        logic [7:0] sum;
        logic       ovf;
        logic       seen;
        logic       vld;
        logic [3:0] care;   // [3]=sum [2]=overflow [1]=overflow_seen [0]=valid
    } exp_t;

    exp_t exp_q[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference state: counter values and the true total after each edge.
    int   mcnt[4];
    int   tot[0:1023];
    int   run    = 0;
    logic p_vld  = 1'b0;
    logic p_ovf  = 1'b0;
    logic p_seen = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    task automatic hand(input string name, input logic [7:0] s, input logic o,
                        input logic sn, input logic v, input logic [3:0] care);
        exp_t e;
        e.edge_n = edges + 1;
        e.name   = name;
        e.sum    = s;
        e.ovf    = o;
        e.seen   = sn;
        e.vld    = v;
        e.care   = care;
        exp_q.push_back(e);
    endtask

    // Apply inputs for the next edge, push the reference expectation, then clock.
    task automatic drive(input logic r, input logic [3:0] en_v, input logic c);
        int   n;
        int   s;
        int   total;
        logic v;
        logic o;
        logic sn;
        exp_t e;
        rst       = r;
        bus.en    = en_v;
        bus.clear = c;
        n = edges + 1;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            if (!r || c) mcnt[i] = 0;
            else if (en_v[i]) mcnt[i] = (mcnt[i] + 1) % 256;
            total += mcnt[i];
        end
        tot[n] = total;
        run = r ? run + 1 : 0;
        v  = (run >= 2);
        s  = v ? tot[n-2] : 0;
        o  = (s > 255);
        sn = (!r || c) ? 1'b0 : (p_seen | (p_vld & p_ovf));
        e.edge_n = n;
        e.name   = "model";
        e.sum    = 8'(s);
        e.ovf    = o;
        e.seen   = sn;
        e.vld    = v;
        e.care   = 4'hF;
        exp_q.push_back(e);
        p_vld  = v;
        p_ovf  = o;
        p_seen = sn;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].edge_n <= edges) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.edge_n != edges) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d not sampled (monitor at edge %0d)",
                         e.name, e.edge_n, edges);
            end else if ((e.care[3] && bus.sum !== e.sum) ||
                         (e.care[2] && bus.overflow !== e.ovf) ||
                         (e.care[1] && bus.overflow_seen !== e.seen) ||
                         (e.care[0] && bus.valid !== e.vld)) begin
                errors++;
                $display("FAIL %s edge %0d: got sum=%02h ovf=%b seen=%b vld=%b, expected sum=%02h ovf=%b seen=%b vld=%b (care=%b)",
                         e.name, edges, bus.sum, bus.overflow, bus.overflow_seen, bus.valid,
                         e.sum, e.ovf, e.seen, e.vld, e.care);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edges);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        tot[0]    = 0;
        rst       = 1'b0;
        bus.en    = 4'hF;
        bus.clear = 1'b0;

        for (int i = 1; i <= 5; i++) begin
            hand("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 4'hF);
            drive(1'b0, 4'hF, 1'b0);
        end

        for (int m = 1; m <= 398; m++) begin
            logic       r;
            logic       c;
            logic [3:0] en_v;
            r    = (m != 393);
            c    = (m == 127) || (m == 130);
            en_v = (m < 130) ? 4'hF : 4'h1;
            case (m)
                1:   hand("first_edge_after_reset", 8'h00, 1'b0, 1'b0, 1'b0, 4'hF);
                2:   hand("valid_rise",             8'h00, 1'b0, 1'b0, 1'b1, 4'hF);
                3:   hand("latency_first",          8'h04, 1'b0, 1'b0, 1'b1, 4'hF);
                10:  hand("sum_0x20",               8'h20, 1'b0, 1'b0, 1'b1, 4'hF);
                65:  hand("pre_overflow",           8'hFC, 1'b0, 1'b0, 1'b1, 4'hF);
                66:  hand("overflow",               8'h00, 1'b1, 1'b0, 1'b1, 4'hF);
                67:  hand("overflow_seen_set",      8'h04, 1'b1, 1'b1, 1'b1, 4'hF);
                126: hand("pre_clear",              8'hF0, 1'b1, 1'b1, 1'b1, 4'hF);
                127: hand("clear_kills_seen",       8'h00, 1'b0, 1'b0, 1'b1, 4'b0011);
                129: hand("post_clear_sum",         8'h00, 1'b0, 1'b0, 1'b1, 4'b1101);
                387: hand("wrap_ff",                8'hFF, 1'b0, 1'b0, 1'b1, 4'hF);
                388: hand("wrap_00",                8'h00, 1'b0, 1'b0, 1'b1, 4'hF);
                392: hand("before_reset",           8'h04, 1'b0, 1'b0, 1'b1, 4'b1101);
                393: hand("mid_reset",              8'h00, 1'b0, 1'b0, 1'b0, 4'hF);
                394: hand("valid_low_after_reset",  8'h00, 1'b0, 1'b0, 1'b0, 4'hF);
                395: hand("valid_back",             8'h00, 1'b0, 1'b0, 1'b1, 4'hF);
                396: hand("restart_count",          8'h01, 1'b0, 1'b0, 1'b1, 4'hF);
                default: ;
            endcase
            drive(r, en_v, c);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never compared", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sum_tree.md
# counter_sum_tree

Parametrised successor to the two-counter/adder test top: CHANNELS independent enable-gated wrap-around counters feed a registered binary adder tree. The tree produces a WIDTH-bit modular sum, a per-sample overflow flag, a sticky overflow flag and an output-valid qualifier. It sits at the top of the multilayer test designs as a deeper, multi-stage stimulus for partitioning across layers.

## Interface
- WIDTH, 8: bit width of each counter and of the `sum` output (≥2)
- CHANNELS, 4: number of counters; power of two, 2..16
- STEP, 1: increment applied to an enabled counter per cycle; 1..2^WIDTH-1
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- en  input  CHANNELS  per-channel count enable, sampled each rising edge
- clear  input  1  synchronous clear of all counters and the sticky flag
- sum  output  WIDTH  low WIDTH bits of the sum of all counters
- overflow  output  1  true sum of the same sample exceeded 2^WIDTH-1
- overflow_seen  output  1  sticky OR of `overflow` while `valid`, since last reset/clear
- valid  output  1  `sum`/`overflow` reflect real counter samples

## Operation
- LEVELS = log2(CHANNELS). Counters are registers `cnt[i]`, WIDTH bits.
- Counter update per edge, in priority order: rst=0 → 0; clear=1 → 0; en[i]=1 → cnt[i]+STEP mod 2^WIDTH; else hold.
- Adder tree: level k (1..LEVELS) holds CHANNELS/2^k registered nodes, each WIDTH+k bits wide, equal to the zero-extended sum of its two children. No truncation inside the tree.
- Final node F is WIDTH+LEVELS bits wide. `sum` = F[WIDTH-1:0]. `overflow` = OR of F[WIDTH+LEVELS-1:WIDTH].
- Valid pipeline: a LEVELS-deep shift register fed with constant 1 and reset to 0. `valid` = its last stage. `clear` does not affect valid.
- Sticky: `overflow_seen` is set on an edge where `valid` and `overflow` are both 1, and reset to 0 by rst=0 or clear=1. Clear wins over a simultaneous set.
- Reset mid-operation: all counters, tree registers, valid stages and sticky return to 0 on the same edge. Nothing survives.

## Timing
- All outputs are 0 during reset and on the first edge after reset.
- Latency: the counter values present after edge t appear on `sum`/`overflow` after edge t+LEVELS.
- `valid` rises after the LEVELS-th edge with rst=1.
- Clear at edge t: counters read 0 after t. `sum` reads the post-clear total (0 if en was low) after edge t+LEVELS. Pre-clear samples still drain through the tree in between.
- `overflow_seen` lags `overflow` by one edge.
- Counter wrap: with STEP=1, a counter at 2^WIDTH-1 wraps to 0. Any other STEP wraps modulo 2^WIDTH.

## Structure
- The shared package `counter_sum_pkg` holds the `clog2` function and the derived constants LEVELS and node width per level.
- Sub-module `add_stage`: one registered tree level. Parameters IN_WIDTH and NODES; 2·NODES inputs in, NODES outputs out. It is generated LEVELS times with widening IN_WIDTH and carries its own synchronous active-low reset.
- Counters and the valid shift register stay inline.

## Test plan
- Reset hold: rst=0 for 5 cycles, en all 1 → sum=0, overflow=0, valid=0, overflow_seen=0 throughout.
- Latency/valid (WIDTH=8, CHANNELS=4): release reset, en=4'b1111 → valid rises after edge 2. After edge 10, sum=4·8=32=0x20, tracking the counters exactly 2 edges late.
- Overflow (WIDTH=8, CHANNELS=4): en=4'b1111 for 64 edges → sum=0x00 with overflow=1 two edges after the counters reach 64. overflow_seen=1 one edge later and stays 1.
- Channel masking and wrap (WIDTH=8, CHANNELS=4): en=4'b0001 for 256 edges → cnt[0] wraps 0xFF→0x00. sum goes 0xFF then 0x00, overflow stays 0.
- Clear priority: clear=1 with en=4'b1111 when sum=0xF0 and overflow_seen=1 → counters=0 next edge and overflow_seen=0. Two edges later sum=0 while valid stays 1.
- Mid-run reset: rst=0 for one edge while valid=1 and sum≠0 → all outputs 0 next edge. valid returns after LEVELS further edges.
